// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter, valid/ready load, strobed shift.
// Define PISO_SHIFT_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] NBITS = CW'(SW);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_shreg;
  logic [SW-1:0] w_shreg_nxt;
  logic [SW-1:0] w_load;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_sout;
  logic          r_done;
  logic          w_done_nxt;
  logic          w_bit_nxt;

`ifdef PISO_SHIFT_TX_PARITY_EN
  logic w_par;
  assign w_par = ^din;
  // parity sits at the tail so it leaves after the last data bit
  assign w_load = (MSB_FIRST != 0) ? {din, w_par} : {w_par, din};
`else
  assign w_load = din;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (load_valid) begin
          w_state_nxt = SHIFT;
          w_shreg_nxt = w_load;
          w_cnt_nxt   = NBITS;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (r_cnt == CW'(1)) begin
            w_state_nxt = IDLE;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            if (MSB_FIRST != 0)
              w_shreg_nxt = {r_shreg[SW-2:0], 1'b0};
            else
              w_shreg_nxt = {1'b0, r_shreg[SW-1:1]};
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // sout is registered from the next-state view of the shift register
  always_comb begin
    w_bit_nxt = 1'b0;
    if (w_state_nxt == SHIFT)
      w_bit_nxt = (MSB_FIRST != 0) ? w_shreg_nxt[SW-1]
                                   : w_shreg_nxt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_sout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sout  <= w_bit_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign load_ready = (r_state == IDLE);
  assign sout_valid = (r_state == SHIFT);
  assign sout       = r_sout;
  assign done       = r_done;

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in, serial-out shift-register transmitter: the sending end of the serial D-flip-flop register chain used in the storage-element labs.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per qualified clock (shift_en strobe), then reports completion.
- Sits between switch/register parallel data and a downstream serial-in register or a board pin.

Parameters:
- WIDTH, 8, number of data bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to transmit.
- load_valid  input  1  din is valid and requests transmission.
- load_ready  output  1  block is idle and accepts a load.
- shift_en  input  1  bit-rate strobe; one shift per clk cycle in which it is high.
- sout  output  1  serial data out.
- sout_valid  output  1  high while a frame is on sout.
- done  output  1  one-cycle pulse after the final bit period ends.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, takes effect immediately): state=IDLE, shift register=0, bit counter=0.
  - Outputs: load_ready=1, sout=0, sout_valid=0, done=0.
- FSM states: IDLE, SHIFT.
- IDLE:
  - load_ready=1, sout=0, sout_valid=0.
  - shift_en is ignored.
  - load_valid=1 at a rising edge: capture din into the shift register, load the counter with WIDTH, go to SHIFT.
- SHIFT:
  - load_ready=0; load_valid and din are ignored.
  - sout_valid=1.
  - sout = shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0; sout is a registered output.
  - Latency: the first bit is on sout in the cycle after the accepting edge.
  - Each rising edge with shift_en=1: shift the register one position toward the output end, fill with 0, decrement the counter.
  - Each bit is held until the next shift_en edge, however many idle cycles pass.
  - Rising edge with shift_en=1 and counter=1: go to IDLE and assert done for exactly the next cycle.
  - In that done cycle: sout=0, sout_valid=0, load_ready=1.
- Back-to-back frames: a load accepted in the done cycle is legal. The next frame starts with no gap beyond that one cycle.
- shift_en held high continuously: one bit per clk; a frame takes WIDTH cycles plus 1 done cycle.
- Counter width: clog2(WIDTH+2) bits. No wrap; the counter never decrements below 1 in SHIFT.
- Reset mid-frame: the frame is abandoned, no done pulse, and all outputs return to reset values immediately.
- done is never asserted in any other case.

Optional Feature:
- Macro: PISO_SHIFT_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH captured bits, computed at load) is appended as the final bit period.
  - The counter loads WIDTH+1; sout_valid stays high through the parity bit.
  - done follows the shift_en edge that ends the parity bit.
- Undefined: no parity logic or storage is present; frames are exactly WIDTH bits.

Test Plan:
- Reset and idle: assert rst_n=0 mid-cycle -> load_ready=1, sout=0, sout_valid=0, done=0 immediately. Pulse shift_en in IDLE -> no change.
- MSB-first frame, WIDTH=8: din=8'hA5, load_valid 1 cycle, shift_en every cycle -> sout=1,0,1,0,0,1,0,1 on 8 consecutive cycles, sout_valid high for those 8, done pulses once on cycle 9.
- Strobe spacing, MSB_FIRST=0: din=8'h01, shift_en every 4th cycle -> sout=1 for 4 cycles, then 0 for 28 cycles. done follows the 8th strobe. load_valid asserted mid-frame is ignored (load_ready=0).
- Back-to-back: din=8'h3C accepted, then din=8'hC3 loaded in the done cycle -> second frame's first bit appears in the cycle after the done cycle, bits 1,1,0,0,0,0,1,1.
- Reset mid-frame: rst_n low after 3 bits of 8'hFF -> sout=0, sout_valid=0 at once, no done. A fresh load after reset transmits normally.
- Parity (PISO_SHIFT_TX_PARITY_EN defined): din=8'h07 -> 8 data bits then parity bit 1, then done. din=8'hA5 -> parity bit 0. Frame is 9 bit periods.
